// File: rtl/core_pkg.sv
// core_pkg: constants and types shared by the RISC-V core.
//   XLEN          datapath / PC width in bits
//   RESET_VECTOR  PC value loaded on reset
//   addr_t        XLEN-bit address type
// The optional misalignment flag on the PC register is enabled with the
// macro PC_ALIGN_CHECK_EN, which is defined at build level, not here.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;

    // A PC is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input addr_t pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/en_dff.sv
// en_dff: a register with a load enable and a synchronous active-low reset.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous reset, active-low, loads RST_VAL
//   load   in   1      capture d at this edge; otherwise hold
//   d      in   W      next value
//   q      out  W      stored value
module en_dff #(
    parameter int          W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/program_counter_reg.sv
// program_counter_reg: architectural PC register at the head of the IF stage.
// Captures the next PC from the next-PC mux and drives the fetch address.
// Update priority at each rising edge: reset, flush (load pc_i), global
// stall (hold), local write enable low (hold), otherwise load pc_i.
// Ports:
//   clk             in   1     system clock
//   rst_n           in   1     synchronous reset, active-low
//   write_en_i      in   1     local PC write enable (0 = load-use hold)
//   global_flush_i  in   1     redirect; loads pc_i regardless of stalls
//   global_stall_i  in   1     global freeze; holds PC
//   pc_i            in   XLEN  next PC
//   pc_o            out  XLEN  current PC, straight from the register
//   pc_misaligned_o out  1     only with PC_ALIGN_CHECK_EN: |PC[1:0] of the
//                              stored value, registered alongside the PC
// Build option: define PC_ALIGN_CHECK_EN to add pc_misaligned_o and a
// simulation warning when a misaligned value is loaded.
module program_counter_reg
    import core_pkg::*;
#(
    parameter int             XLEN_P         = XLEN,
    parameter logic [XLEN_P-1:0] RESET_VECTOR_P = RESET_VECTOR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en_i,
    input  logic              global_flush_i,
    input  logic              global_stall_i,
    input  logic [XLEN_P-1:0] pc_i,
`ifdef PC_ALIGN_CHECK_EN
    output logic              pc_misaligned_o,
`endif
    output logic [XLEN_P-1:0] pc_o
);

    logic load;

    // Flush is a redirect and must win over both stall sources.
    assign load = global_flush_i | (~global_stall_i & write_en_i);

    en_dff #(
        .W       (XLEN_P),
        .RST_VAL (RESET_VECTOR_P)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .d     (pc_i),
        .q     (pc_o)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_d;

    // Computed from the incoming value so the flag is registered in step
    // with the PC rather than decoded combinationally from pc_o.
    assign misaligned_d = |pc_i[1:0];

    en_dff #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_misaligned (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .d     (misaligned_d),
        .q     (pc_misaligned_o)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && load && misaligned_d) begin
            $warning("program_counter_reg: misaligned PC load 0x%0h", pc_i);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_program_counter_reg.sv
module tb_program_counter_reg;
    import core_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  write_en_i;
    logic  global_flush_i;
    logic  global_stall_i;
    addr_t pc_i;
    addr_t pc_o;
`ifdef PC_ALIGN_CHECK_EN
    logic  pc_misaligned_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference: what the PC should be, derived from the priority rules.
    addr_t ref_pc;

    program_counter_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_en_i     (write_en_i),
        .global_flush_i (global_flush_i),
        .global_stall_i (global_stall_i),
        .pc_i           (pc_i),
`ifdef PC_ALIGN_CHECK_EN
        .pc_misaligned_o(pc_misaligned_o),
`endif
        .pc_o           (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_pc(input string tag, input addr_t exp);
        tests_run++;
        assert (pc_o === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: pc_o=0x%08h expected=0x%08h", tag, pc_o, exp);
        end
`ifdef PC_ALIGN_CHECK_EN
        tests_run++;
        assert (pc_misaligned_o === (exp[1] | exp[0]))
        else begin
            tests_failed++;
            $error("FAIL %s_mis: pc_misaligned_o=%b expected=%b", tag,
                   pc_misaligned_o, exp[1] | exp[0]);
        end
`endif
    endtask

    // Apply one clock edge: predict the next PC from the currently driven
    // inputs, then sample the DUT 1 time unit after the edge.
    task automatic tick();
        if (!rst_n)               ref_pc = RESET_VECTOR;
        else if (global_flush_i)  ref_pc = pc_i;
        else if (global_stall_i)  ref_pc = ref_pc;
        else if (!write_en_i)     ref_pc = ref_pc;
        else                      ref_pc = pc_i;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic fl,
                         input logic st, input addr_t pc);
        rst_n          = r;
        write_en_i     = we;
        global_flush_i = fl;
        global_stall_i = st;
        pc_i           = pc;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        ref_pc = 'x;
        @(negedge clk);

        // Reset ignores pc_i
        tick();
        check_pc("reset", 32'h0000_0000);

        // Update
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h4);
        tick();
        check_pc("update", 32'h4);

        // Local hold, then release
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8);
        tick();
        check_pc("local_hold", 32'h4);
        tick();
        check_pc("local_hold2", 32'h4);
        write_en_i = 1'b1;
        tick();
        check_pc("local_release", 32'h8);

        // Global stall over 3 edges
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pc("global_stall", 32'h8);
        end

        // Flush beats stall and write-enable low
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        tick();
        check_pc("flush_priority", 32'h100);

        // Reset is synchronous: no change between edges
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h102);
        #2;
        check_pc("reset_sync_between_edges", 32'h100);
        tick();
        check_pc("reset_midrun", RESET_VECTOR);

        // First edge after release behaves normally
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h102);
        tick();
        check_pc("post_reset_load_unaligned", 32'h102);

        // Bit-exact storage of extreme values
        pc_i = 32'hFFFF_FFFF;
        tick();
        check_pc("all_ones", 32'hFFFF_FFFF);
        pc_i = 32'h0000_0000;
        tick();
        check_pc("all_zeros", 32'h0000_0000);

        // Randomized control/data against the reference
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) != 0),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0),
                  $urandom());
            tick();
            check_pc("random", ref_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
